mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage directly downstream of the execute unit.
- Consumes the EX results: ls_address, the store source operand, and non-memory ALU/BJU/MULDIV results.
- Issues one load or store at a time to the data cache over a valid/ready request and valid response interface. Aligns load data and sign- or zero-extends it.
- Produces a registered writeback packet. The same register drives the mem_byp_* load-to-use bypass back into EX.

Parameters:
- XLEN, 64, data and address width
- LREG_W, 5, logical register index width

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  kill the in-flight and incoming op (redirect)
- in_valid  in  1  EX packet valid
- in_ready  out  1  stage can accept a packet
- in_rd  in  LREG_W  destination register
- in_need_to_wb  in  1  op writes rd
- in_is_load  in  1  load op
- in_is_store  in  1  store op
- in_is_unsigned  in  1  zero-extend load
- in_ls_size  in  4  one-hot size: [0] byte, [1] half, [2] word, [3] double
- in_ls_address  in  XLEN  effective address
- in_store_data  in  XLEN  store source (rs2 value)
- in_ex_result  in  XLEN  non-memory result
- in_pc  in  XLEN  instruction PC
- dreq_valid  out  1  cache request valid
- dreq_ready  in  1  cache accepts request
- dreq_addr  out  XLEN  address with [2:0] forced to 0
- dreq_wen  out  1  1 = store
- dreq_wdata  out  XLEN  lane-shifted store data
- dreq_wmask  out  8  byte enables
- dresp_valid  in  1  cache response
- dresp_data  in  XLEN  aligned 8-byte line word
- out_valid  out  1  writeback packet valid (1-cycle pulse)
- out_rd  out  LREG_W  destination
- out_need_to_wb  out  1  write rd
- out_result  out  XLEN  writeback data
- out_pc  out  XLEN  PC
- out_misalign  out  1  misaligned access flagged
- mem_byp_rd  out  LREG_W  equals out_rd
- mem_byp_need_to_wb  out  1  out_valid & out_need_to_wb
- mem_byp_result  out  XLEN  equals out_result

Behaviour:
- Reset (async, active-high):
  - state = IDLE, killed = 0.
  - All out_* and dreq_* outputs are 0; mem_byp_* are 0.
- in_ready = (state == IDLE). Accept = in_valid & in_ready & !flush. Writeback is always accepted; no output backpressure.
- States:
  - IDLE
  - REQ: dreq_valid held with stable addr/wen/wdata/wmask until dreq_ready.
  - WAIT: awaiting dresp_valid.
- Non-memory op accepted:
  - Next cycle: out_valid = 1, out_result = in_ex_result. State stays IDLE.
  - Latency 1.
- Misalign check at accept: address[0] for half, address[1:0] for word, address[2:0] for double must be zero.
  - If not zero: no cache request.
  - Next cycle: out_valid = 1, out_misalign = 1, out_need_to_wb = 0, out_result = address.
- Aligned load/store accepted:
  - IDLE -> REQ.
  - REQ & dreq_ready -> WAIT.
  - WAIT & dresp_valid -> IDLE, with out_valid = 1 the following cycle.
  - Minimum latency accept-to-out_valid is 3 cycles. dresp_valid outside WAIT is ignored.
- Store lanes:
  - off = addr[2:0].
  - wmask = (size mask 0x01/0x03/0x0F/0xFF) << off.
  - wdata = store_data << (8*off).
  - Store writeback: out_need_to_wb = 0, out_result = 0.
- Load extraction:
  - raw = dresp_data >> (8*off), truncated to the size.
  - Sign-extended unless in_is_unsigned. Double ignores the unsigned flag.
- Flush:
  - flush with in_valid in IDLE: packet dropped, nothing accepted.
  - flush in REQ: dreq_valid deasserts next cycle, return to IDLE. If dreq_ready is also high that cycle, go to WAIT with killed = 1.
  - flush in WAIT: killed = 1. On dresp_valid, return to IDLE with no out_valid.
  - killed clears on leaving WAIT.
  - flush does not cancel an already-registered out_valid.
- out_* hold their last value when out_valid = 0, but mem_byp_need_to_wb is 0 whenever out_valid is 0.
- ls_size with zero or multiple bits set is treated as double. Both is_load and is_store set is treated as store.

Test Plan:
- Non-memory op: in_ex_result = 0x1234, rd = 5 -> next cycle out_valid = 1, out_result = 0x1234, mem_byp_rd = 5, mem_byp_need_to_wb = 1.
- Signed byte load: addr 0x1003, dresp_data = 0x00000000_80000000 arriving 1 cycle after the handshake -> dreq_addr = 0x1000; out_result = 0xFFFFFFFF_FFFFFF80, with out_valid 3 cycles after accept.
- Unsigned half load at addr 0x1006, dresp_data = 0xBEEF0000_00000000 -> out_result = 0xBEEF. The same load with is_unsigned = 0 -> 0xFFFF_FFFF_FFFF_BEEF.
- Word store: addr 0x2004, data 0xAABBCCDD -> dreq_wmask = 0xF0, dreq_wdata = 0xAABBCCDD_00000000, dreq_wen = 1. With dreq_ready low for 3 cycles, the request is held stable; out_need_to_wb = 0.
- Misaligned double load at addr 0x3004 -> no dreq_valid; next cycle out_misalign = 1, out_need_to_wb = 0, out_result = 0x3004.
- Flush during WAIT, then dresp_valid -> no out_valid; in_ready returns to 1. Reset asserted mid-REQ -> dreq_valid drops immediately (async) and state is IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues one load/store at a time to the data cache, aligns and
// extends load data, and registers a writeback packet that also feeds the EX bypass.
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int LREG_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LREG_W-1:0] in_rd,
  input  logic              in_need_to_wb,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic              in_is_unsigned,
  input  logic [3:0]        in_ls_size,
  input  logic [XLEN-1:0]   in_ls_address,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_ex_result,
  input  logic [XLEN-1:0]   in_pc,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic [XLEN-1:0]   dreq_addr,
  output logic              dreq_wen,
  output logic [XLEN-1:0]   dreq_wdata,
  output logic [7:0]        dreq_wmask,
  input  logic              dresp_valid,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              out_valid,
  output logic [LREG_W-1:0] out_rd,
  output logic              out_need_to_wb,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_misalign,
  output logic [LREG_W-1:0] mem_byp_rd,
  output logic              mem_byp_need_to_wb,
  output logic [XLEN-1:0]   mem_byp_result
);

  // state | meaning
  // IDLE  | ready for a new EX packet
  // REQ   | cache request held until dreq_ready
  // WAIT  | request accepted, awaiting dresp_valid (dropped if killed)
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;
  logic killed_q, killed_d;

  logic            dreq_valid_q, dreq_valid_d;
  logic [XLEN-1:0] dreq_addr_q, dreq_addr_d;
  logic            dreq_wen_q, dreq_wen_d;
  logic [XLEN-1:0] dreq_wdata_q, dreq_wdata_d;
  logic [7:0]      dreq_wmask_q, dreq_wmask_d;

  logic [LREG_W-1:0] rd_q, rd_d;
  logic              need_wb_q, need_wb_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [2:0]        off_q, off_d;
  logic [XLEN-1:0]   pc_q, pc_d;

  logic              out_valid_q, out_valid_d;
  logic [LREG_W-1:0] out_rd_q, out_rd_d;
  logic              out_need_to_wb_q, out_need_to_wb_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic              out_misalign_q, out_misalign_d;

  logic            accept;
  logic            is_mem;
  logic [1:0]      in_sz;
  logic            misalign;
  logic [7:0]      size_mask;
  logic [2:0]      in_off;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign is_mem   = in_is_load | in_is_store;
  assign in_off   = in_ls_address[2:0];

  // Anything other than a clean one-hot size is treated as a double.
  always_comb begin
    in_sz     = 2'd3;
    size_mask = 8'hFF;
    misalign  = |in_ls_address[2:0];
    case (in_ls_size)
      4'b0001: begin in_sz = 2'd0; size_mask = 8'h01; misalign = 1'b0;                 end
      4'b0010: begin in_sz = 2'd1; size_mask = 8'h03; misalign = in_ls_address[0];     end
      4'b0100: begin in_sz = 2'd2; size_mask = 8'h0F; misalign = |in_ls_address[1:0];  end
      default: ;
    endcase
  end

  assign ld_shift = dresp_data >> {off_q, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (size_q)
      2'd0: ld_data = uns_q ? {{(XLEN-8){1'b0}},  ld_shift[7:0]}
                            : {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
      2'd1: ld_data = uns_q ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                            : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_data = uns_q ? {{(XLEN-32){1'b0}}, ld_shift[31:0]}
                            : {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    killed_d         = killed_q;
    dreq_valid_d     = dreq_valid_q;
    dreq_addr_d      = dreq_addr_q;
    dreq_wen_d       = dreq_wen_q;
    dreq_wdata_d     = dreq_wdata_q;
    dreq_wmask_d     = dreq_wmask_q;
    rd_d             = rd_q;
    need_wb_d        = need_wb_q;
    uns_d            = uns_q;
    size_d           = size_q;
    off_d            = off_q;
    pc_d             = pc_q;
    out_valid_d      = 1'b0;
    out_rd_d         = out_rd_q;
    out_need_to_wb_d = out_need_to_wb_q;
    out_result_d     = out_result_q;
    out_pc_d         = out_pc_q;
    out_misalign_d   = out_misalign_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem && !misalign) begin
            state_d      = REQ;
            dreq_valid_d = 1'b1;
            dreq_addr_d  = {in_ls_address[XLEN-1:3], 3'b000};
            dreq_wen_d   = in_is_store;
            dreq_wdata_d = in_store_data << {in_off, 3'b000};
            dreq_wmask_d = size_mask << in_off;
            rd_d         = in_rd;
            need_wb_d    = in_need_to_wb & ~in_is_store;
            uns_d        = in_is_unsigned;
            size_d       = in_sz;
            off_d        = in_off;
            pc_d         = in_pc;
          end else begin
            out_valid_d      = 1'b1;
            out_rd_d         = in_rd;
            out_pc_d         = in_pc;
            out_misalign_d   = is_mem;
            out_need_to_wb_d = is_mem ? 1'b0 : in_need_to_wb;
            out_result_d     = is_mem ? in_ls_address : in_ex_result;
          end
        end
      end
      REQ: begin
        if (dreq_ready) begin
          dreq_valid_d = 1'b0;
          state_d      = WAIT;
          killed_d     = flush;
        end else if (flush) begin
          dreq_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      WAIT: begin
        if (dresp_valid) begin
          state_d  = IDLE;
          killed_d = 1'b0;
          if (!killed_q && !flush) begin
            out_valid_d      = 1'b1;
            out_rd_d         = rd_q;
            out_pc_d         = pc_q;
            out_misalign_d   = 1'b0;
            out_need_to_wb_d = need_wb_q;
            out_result_d     = dreq_wen_q ? '0 : ld_data;
          end
        end else if (flush) begin
          killed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      killed_q         <= 1'b0;
      dreq_valid_q     <= 1'b0;
      dreq_addr_q      <= '0;
      dreq_wen_q       <= 1'b0;
      dreq_wdata_q     <= '0;
      dreq_wmask_q     <= '0;
      rd_q             <= '0;
      need_wb_q        <= 1'b0;
      uns_q            <= 1'b0;
      size_q           <= '0;
      off_q            <= '0;
      pc_q             <= '0;
      out_valid_q      <= 1'b0;
      out_rd_q         <= '0;
      out_need_to_wb_q <= 1'b0;
      out_result_q     <= '0;
      out_pc_q         <= '0;
      out_misalign_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      killed_q         <= killed_d;
      dreq_valid_q     <= dreq_valid_d;
      dreq_addr_q      <= dreq_addr_d;
      dreq_wen_q       <= dreq_wen_d;
      dreq_wdata_q     <= dreq_wdata_d;
      dreq_wmask_q     <= dreq_wmask_d;
      rd_q             <= rd_d;
      need_wb_q        <= need_wb_d;
      uns_q            <= uns_d;
      size_q           <= size_d;
      off_q            <= off_d;
      pc_q             <= pc_d;
      out_valid_q      <= out_valid_d;
      out_rd_q         <= out_rd_d;
      out_need_to_wb_q <= out_need_to_wb_d;
      out_result_q     <= out_result_d;
      out_pc_q         <= out_pc_d;
      out_misalign_q   <= out_misalign_d;
    end
  end

  assign dreq_valid         = dreq_valid_q;
  assign dreq_addr          = dreq_addr_q;
  assign dreq_wen           = dreq_wen_q;
  assign dreq_wdata         = dreq_wdata_q;
  assign dreq_wmask         = dreq_wmask_q;
  assign out_valid          = out_valid_q;
  assign out_rd             = out_rd_q;
  assign out_need_to_wb     = out_need_to_wb_q;
  assign out_result         = out_result_q;
  assign out_pc             = out_pc_q;
  assign out_misalign       = out_misalign_q;
  assign mem_byp_rd         = out_rd_q;
  assign mem_byp_need_to_wb = out_valid_q & out_need_to_wb_q;
  assign mem_byp_result     = out_result_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback packets are queued at
// issue and compared when out_valid fires; a scripted cache drives dreq/dresp.
module tb_mem_stage;
  localparam int XLEN   = 64;
  localparam int LREG_W = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [LREG_W-1:0] in_rd;
  logic              in_need_to_wb, in_is_load, in_is_store, in_is_unsigned;
  logic [3:0]        in_ls_size;
  logic [XLEN-1:0]   in_ls_address, in_store_data, in_ex_result, in_pc;
  logic              dreq_valid, dreq_ready, dreq_wen;
  logic [XLEN-1:0]   dreq_addr, dreq_wdata;
  logic [7:0]        dreq_wmask;
  logic              dresp_valid;
  logic [XLEN-1:0]   dresp_data;
  logic              out_valid, out_need_to_wb, out_misalign;
  logic [LREG_W-1:0] out_rd, mem_byp_rd;
  logic [XLEN-1:0]   out_result, out_pc, mem_byp_result;
  logic              mem_byp_need_to_wb;

  mem_stage #(.XLEN(XLEN), .LREG_W(LREG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_need_to_wb(in_need_to_wb), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_is_unsigned(in_is_unsigned), .in_ls_size(in_ls_size), .in_ls_address(in_ls_address),
    .in_store_data(in_store_data), .in_ex_result(in_ex_result), .in_pc(in_pc),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_wen(dreq_wen), .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_rd(out_rd), .out_need_to_wb(out_need_to_wb),
    .out_result(out_result), .out_pc(out_pc), .out_misalign(out_misalign),
    .mem_byp_rd(mem_byp_rd), .mem_byp_need_to_wb(mem_byp_need_to_wb),
    .mem_byp_result(mem_byp_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic        nwb;
    logic [63:0] res;
    logic [63:0] pc;
    logic        mis;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
        check("out_need_to_wb", {63'd0, out_need_to_wb}, {63'd0, e.nwb});
        check("out_result", out_result, e.res);
        check("out_pc", out_pc, e.pc);
        check("out_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
        check("byp_rd", {59'd0, mem_byp_rd}, {59'd0, e.rd});
        check("byp_need_to_wb", {63'd0, mem_byp_need_to_wb}, {63'd0, e.nwb});
        check("byp_result", mem_byp_result, e.res);
        if (e.exp_cyc >= 0) check("latency", 64'(cyc), 64'(e.exp_cyc));
      end
    end
  end

  function automatic logic [63:0] ld_model(input logic [63:0] d, input int off,
                                           input int nbytes, input logic uns);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < nbytes; b++) r[8*b +: 8] = d[8*(off+b) +: 8];
    if (!uns && nbytes < 8 && r[8*nbytes-1])
      for (int b = 8*nbytes; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  // Presents one packet for one cycle; optionally queues its expected writeback.
  task automatic drive(input logic [4:0] rd, input logic nwb, input logic ld, input logic st,
                       input logic uns, input logic [3:0] sz, input logic [63:0] addr,
                       input logic [63:0] sdata, input logic [63:0] exres, input logic [63:0] pc,
                       input logic fl, input logic push, input exp_t x, input int lat);
    exp_t y;
    @(negedge clock);
    in_valid = 1'b1; in_rd = rd; in_need_to_wb = nwb; in_is_load = ld; in_is_store = st;
    in_is_unsigned = uns; in_ls_size = sz; in_ls_address = addr; in_store_data = sdata;
    in_ex_result = exres; in_pc = pc; flush = fl;
    check("in_ready_before", {63'd0, in_ready}, 64'd1);
    if (push) begin
      y = x;
      y.exp_cyc = (lat >= 0) ? cyc + lat : -1;
      sb.push_back(y);
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  // Scripted cache: checks the held request, accepts after rdy_dly cycles, responds resp_dly later.
  task automatic do_mem(input int rdy_dly, input int resp_dly, input logic [63:0] rdata,
                        input logic [63:0] eaddr, input logic ewen,
                        input logic [63:0] ewdata, input logic [7:0] ewmask);
    int n;
    n = 0;
    while (dreq_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check("dreq_valid", {63'd0, dreq_valid}, 64'd1);
    if (dreq_valid !== 1'b1) return;
    for (int i = 0; i <= rdy_dly; i++) begin
      check("dreq_addr", dreq_addr, eaddr);
      check("dreq_wen", {63'd0, dreq_wen}, {63'd0, ewen});
      if (ewen) begin
        check("dreq_wdata", dreq_wdata, ewdata);
        check("dreq_wmask", {56'd0, dreq_wmask}, {56'd0, ewmask});
      end
      if (i == rdy_dly) dreq_ready = 1'b1;
      @(negedge clock);
    end
    dreq_ready = 1'b0;
    check("dreq_valid_drop", {63'd0, dreq_valid}, 64'd0);
    repeat (resp_dly) @(negedge clock);
    dresp_valid = 1'b1; dresp_data = rdata;
    @(negedge clock);
    dresp_valid = 1'b0;
  endtask

  exp_t x;
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd = '0; in_need_to_wb = 1'b0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_is_unsigned = 1'b0; in_ls_size = 4'b0001;
    in_ls_address = '0; in_store_data = '0; in_ex_result = '0; in_pc = '0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = '0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_dreq_wmask", {56'd0, dreq_wmask}, 64'd0);
    check("rst_byp_nwb", {63'd0, mem_byp_need_to_wb}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Non-memory op
    x = '{rd: 5'd5, nwb: 1'b1, res: 64'h1234, pc: 64'h100, mis: 1'b0, exp_cyc: -1};
    drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 64'h0, 64'h0, 64'h1234, 64'h100, 1'b0, 1'b1, x, 1);
    check("nonmem_no_dreq", {63'd0, dreq_valid}, 64'd0);

    // Signed byte load, minimum latency
    x = '{rd: 5'd7, nwb: 1'b1, res: 64'hFFFFFFFF_FFFFFF80, pc: 64'h104, mis: 1'b0, exp_cyc: -1};
    drive(5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 64'h1003, 64'h0, 64'h0, 64'h104, 1'b0, 1'b1, x, 3);
    do_mem(0, 0, 64'h00000000_80000000, 64'h1000, 1'b0, 64'h0, 8'h0);

    // Half load, unsigned then signed
    x = '{rd: 5'd8, nwb: 1'b1, res: 64'hBEEF, pc: 64'h108, mis: 1'b0, exp_cyc: -1};
    drive(5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 64'h1006, 64'h0, 64'h0, 64'h108, 1'b0, 1'b1, x, -1);
    do_mem(1, 1, 64'hBEEF0000_00000000, 64'h1000, 1'b0, 64'h0, 8'h0);
    x = '{rd: 5'd9, nwb: 1'b1, res: 64'hFFFFFFFF_FFFFBEEF, pc: 64'h10C, mis: 1'b0, exp_cyc: -1};
    drive(5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 64'h1006, 64'h0, 64'h0, 64'h10C, 1'b0, 1'b1, x, -1);
    do_mem(0, 2, 64'hBEEF0000_00000000, 64'h1000, 1'b0, 64'h0, 8'h0);

    // Word store with ready held low for 3 cycles
    x = '{rd: 5'd3, nwb: 1'b0, res: 64'h0, pc: 64'h110, mis: 1'b0, exp_cyc: -1};
    drive(5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 64'h2004, 64'hAABBCCDD, 64'h0, 64'h110, 1'b0, 1'b1, x, -1);
    do_mem(3, 0, 64'h0, 64'h2000, 1'b1, 64'hAABBCCDD_00000000, 8'hF0);

    // Load+store together behaves as a store; byte lane 1
    x = '{rd: 5'd4, nwb: 1'b0, res: 64'h0, pc: 64'h114, mis: 1'b0, exp_cyc: -1};
    drive(5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 64'h2009, 64'h5A, 64'h0, 64'h114, 1'b0, 1'b1, x, -1);
    do_mem(0, 0, 64'h0, 64'h2008, 1'b1, 64'h5A00, 8'h02);

    // Misaligned double load
    x = '{rd: 5'd10, nwb: 1'b0, res: 64'h3004, pc: 64'h118, mis: 1'b1, exp_cyc: -1};
    drive(5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 64'h3004, 64'h0, 64'h0, 64'h118, 1'b0, 1'b1, x, 1);
    check("misalign_no_dreq", {63'd0, dreq_valid}, 64'd0);

    // Zero size is a double: misaligned at offset 4
    x = '{rd: 5'd11, nwb: 1'b0, res: 64'h3014, pc: 64'h11C, mis: 1'b1, exp_cyc: -1};
    drive(5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 64'h3014, 64'h0, 64'h0, 64'h11C, 1'b0, 1'b1, x, 1);

    // Multi-hot size is a double; unsigned flag ignored
    x = '{rd: 5'd12, nwb: 1'b1, res: 64'h80112233_44556677, pc: 64'h120, mis: 1'b0, exp_cyc: -1};
    drive(5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 64'h5000, 64'h0, 64'h0, 64'h120, 1'b0, 1'b1, x, -1);
    do_mem(0, 0, 64'h80112233_44556677, 64'h5000, 1'b0, 64'h0, 8'h0);

    // Randomized aligned loads against the byte model
    for (int k = 0; k < 8; k++) begin
      int idx, nb, off;
      logic uns, nwb;
      logic [63:0] d, a;
      idx = $urandom_range(0, 3);
      nb  = 1 << idx;
      off = $urandom_range(0, 7) & ~(nb - 1);
      uns = 1'($urandom_range(0, 1));
      nwb = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      a   = 64'h4000 + 64'(off);
      x = '{rd: 5'(k + 16), nwb: nwb, res: ld_model(d, off, nb, uns), pc: 64'h200 + 64'(4*k),
            mis: 1'b0, exp_cyc: -1};
      drive(5'(k + 16), nwb, 1'b1, 1'b0, uns, 4'(1 << idx), a, 64'h0, 64'h0,
            64'h200 + 64'(4*k), 1'b0, 1'b1, x, -1);
      do_mem($urandom_range(0, 2), $urandom_range(0, 2), d, 64'h4000, 1'b0, 64'h0, 8'h0);
    end

    // Flush with in_valid in IDLE: dropped
    drive(5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 64'h0, 64'h0, 64'h77, 64'h300, 1'b1, 1'b0, x, -1);
    check("idle_flush_no_out", {63'd0, out_valid}, 64'd0);

    // Flush during WAIT, then response: no writeback
    drive(5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 64'h6000, 64'h0, 64'h0, 64'h304, 1'b0, 1'b0, x, -1);
    dreq_ready = 1'b1;
    @(negedge clock); dreq_ready = 1'b0; flush = 1'b1;
    @(negedge clock); flush = 1'b0; dresp_valid = 1'b1; dresp_data = 64'h1;
    @(negedge clock); dresp_valid = 1'b0;
    check("wait_flush_no_out", {63'd0, out_valid}, 64'd0);
    check("wait_flush_ready", {63'd0, in_ready}, 64'd1);

    // Flush in REQ without ready: back to IDLE
    drive(5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 64'h6000, 64'h0, 64'h0, 64'h308, 1'b0, 1'b0, x, -1);
    flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    check("req_flush_dreq_drop", {63'd0, dreq_valid}, 64'd0);
    check("req_flush_ready", {63'd0, in_ready}, 64'd1);

    // Flush in REQ with ready: killed in WAIT
    drive(5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 64'h6000, 64'h0, 64'h0, 64'h30C, 1'b0, 1'b0, x, -1);
    flush = 1'b1; dreq_ready = 1'b1;
    @(negedge clock); flush = 1'b0; dreq_ready = 1'b0;
    check("req_flush_hs_busy", {63'd0, in_ready}, 64'd0);
    dresp_valid = 1'b1;
    @(negedge clock); dresp_valid = 1'b0;
    check("req_flush_hs_no_out", {63'd0, out_valid}, 64'd0);
    check("req_flush_hs_ready", {63'd0, in_ready}, 64'd1);

    // Stray response in IDLE is ignored
    dresp_valid = 1'b1;
    @(negedge clock); dresp_valid = 1'b0;
    check("stray_resp_no_out", {63'd0, out_valid}, 64'd0);
    check("idle_byp_nwb", {63'd0, mem_byp_need_to_wb}, 64'd0);

    // Async reset mid-REQ
    drive(5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 64'h7000, 64'h0, 64'h0, 64'h310, 1'b0, 1'b0, x, -1);
    check("req_before_reset", {63'd0, dreq_valid}, 64'd1);
    reset = 1'b1;
    #1;
    check("reset_dreq_drop", {63'd0, dreq_valid}, 64'd0);
    check("reset_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clock); reset = 1'b0;

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
